radicador_param: RTL and testbench
==================================

# radicador_param

Parametrised non-restoring integer square-root unit, the next generation of the fixed 32→16 radicador. It accepts any even input width, returns both root and remainder, and offers truncate or round-to-nearest mode. It also adds a BUSY flag, a synchronous abort, and a saturation flag. It sits behind the measurement-processing datapath, for example RMS or magnitude computation, and is driven by a controlling FSM through the START/FIN level handshake.

## Interface
- W_IN, 32: input width; must be even and ≥ 4. N = W_IN/2 is the root width.
- ROUND, 0: 0 truncates (floor); 1 rounds to nearest.
- CLK  in  1  system clock; all state updates on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  request; level-sampled in IDLE, must be dropped to release DONE.
- ABORT  in  1  synchronous abort; returns the block to IDLE from any state.
- X  in  W_IN  unsigned radicand; captured on the START edge only.
- BUSY  out  1  high in ITER and CORR.
- FIN  out  1  high only in DONE; decoded from state.
- ROOT  out  N  result; held stable in DONE.
- REM  out  N+1  remainder X − ROOT², computed before rounding.
- SAT  out  1  rounding would overflow N bits; ROOT is held at all-ones.

## Operation
- States: IDLE, ITER, CORR, DONE.
  - IDLE → ITER when START=1. Load a←X, q←0, r←0 (N+2 bits signed), cnt←0.
  - ITER runs N cycles. Each cycle:
    - left = {r[N-1:0], a[W_IN-1:W_IN-2]}
    - right = {q, r[N+1], 1}
    - temp = r negative ? left+right : left−right
    - r←temp; q←{q[N-2:0], ~temp[N+1]}; a←a<<2
    - When cnt = N−1, go to CORR.
  - CORR, one cycle:
    - If r is negative, set r←r+{q,1}. Then REM←r[N:0].
    - With ROUND=0: ROOT←q.
    - With ROUND=1: if REM > q, ROOT←q+1. If q is all-ones in that case, ROOT←q and SAT←1.
    - Next state is DONE.
  - DONE: stay while START=1; go to IDLE when START=0.
- ABORT=1 in any state: next state is IDLE. ROOT, REM and SAT keep their old values and FIN does not pulse. ABORT has priority over START in IDLE.
- A change on X outside the IDLE capture edge has no effect.
- Reset values: state IDLE, FIN=0, BUSY=0, ROOT=0, REM=0, SAT=0. All internal registers are cleared.
- ROOT, REM and SAT update only on the CORR→DONE edge. SAT clears on the next accepted START.

## Timing
- START is sampled high at edge k. ITER occupies edges k+1…k+N. CORR finishes at edge k+N+1.
- FIN and outputs are valid from edge k+N+1: N+1 cycles after capture, which is 17 for W_IN=32.
- BUSY is high from edge k to edge k+N+1.
- The minimum repeat interval is N+3 cycles: START must be seen low for one cycle in DONE.
- If START is held high through DONE, there is no restart; the block stays in DONE.
- RESET asserted mid-operation forces immediate return to reset values, without waiting for a clock edge.

## Structure
- Package radicador_pkg holds:
  - typedef enum logic [1:0] {IDLE, ITER, CORR, DONE} rad_state_t
  - function clog2-based counter width, ceil(log2 N)
- Sub-module radicador_etapa, parametrised by N: one combinational add/subtract step. It takes r, q and the 2-bit slice, and returns temp and the next q bit. It is instantiated once, inside ITER.

## Test plan
- W_IN=32, ROUND=0, X=0 → ROOT=0, REM=0, SAT=0; FIN rises exactly 17 cycles after the START capture.
- W_IN=32, ROUND=0, X=0xFFFFFFFF → ROOT=0xFFFF, REM=0x1FFFE. With ROUND=1, the same X gives ROOT=0xFFFF, SAT=1.
- W_IN=32, ROUND=1:
  - X=3 → ROOT=2, REM=2.
  - X=2 → ROOT=1, REM=1.
  - X=0x00010000 → ROOT=0x100, REM=0.
- W_IN=8, X=200 → ROOT=14, REM=4, FIN after 5 cycles. Also run 256 random/exhaustive X values against a floor-sqrt model.
- ABORT at ITER cycle 3 → IDLE next cycle, FIN never rises, previous ROOT/REM retained. A new START then completes normally.
- RESET low mid-ITER → all outputs 0 immediately, state IDLE. START held high after FIN → remains in DONE with outputs stable until START falls.

Source files
------------

// File: rtl/radicador_pkg.sv
// Shared types and helpers for the parametrised square-root unit.
package radicador_pkg;

  typedef enum logic [1:0] {IDLE, ITER, CORR, DONE} rad_state_t;

  // Width of the iteration counter that must reach n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/radicador_etapa.sv
// One non-restoring square-root step: add or subtract the trial divisor
// depending on the sign of the running remainder, and derive the next root bit.
module radicador_etapa #(
  parameter int N = 16
) (
  input  logic [N+1:0] r,
  input  logic [N-1:0] q,
  input  logic [1:0]   pair,
  output logic [N+1:0] temp,
  output logic         q_bit
);

  logic [N+1:0] left;
  logic [N+1:0] right;

  // Shift in the next radicand pair; a negative remainder adds instead of subtracting.
  always_comb begin
    left  = {r[N-1:0], pair};
    right = {q, r[N+1], 1'b1};
    temp  = r[N+1] ? (left + right) : (left - right);
    q_bit = ~temp[N+1];
  end

endmodule

// File: rtl/radicador_param.sv
// Iterative non-restoring integer square root: one root bit per cycle,
// a single correction cycle, optional round-to-nearest with saturation.
module radicador_param
  import radicador_pkg::*;
#(
  parameter int W_IN  = 32,
  parameter bit ROUND = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [W_IN-1:0]     x,
  output logic                busy,
  output logic                fin,
  output logic [W_IN/2-1:0]   root,
  output logic [W_IN/2:0]     rem,
  output logic                sat
);

  localparam int N  = W_IN / 2;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  rad_state_t      state, state_nxt;
  logic [W_IN-1:0] a;
  logic [N-1:0]    q;
  logic [N+1:0]    r;
  logic [CW-1:0]   cnt;

  logic [N+1:0]    temp;
  logic            q_bit;

  logic [N+1:0]    r_fix;
  logic [N:0]      rem_c;
  logic [N-1:0]    root_c;
  logic            sat_c;

  radicador_etapa #(.N(N)) u_etapa (
    .r    (r),
    .q    (q),
    .pair (a[W_IN-1:W_IN-2]),
    .temp (temp),
    .q_bit(q_bit)
  );

  assign busy = (state == ITER) || (state == CORR);
  assign fin  = (state == DONE);

  // Next-state decode; abort overrides everything, including a pending start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ITER;
      ITER:    if (cnt == LAST) state_nxt = CORR;
      CORR:    state_nxt = DONE;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Final remainder fix-up and optional rounding, consumed in CORR.
  always_comb begin
    r_fix = r;
    if (r[N+1]) r_fix = r + {1'b0, q, 1'b1};
    rem_c  = r_fix[N:0];
    root_c = q;
    sat_c  = 1'b0;
    if (ROUND && (rem_c > {1'b0, q})) begin
      if (&q) sat_c  = 1'b1;
      else    root_c = q + 1'b1;
    end
  end

  // State, datapath and result registers; results only move on CORR->DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a     <= '0;
      q     <= '0;
      r     <= '0;
      cnt   <= '0;
      root  <= '0;
      rem   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start && !abort) begin
          a   <= x;
          q   <= '0;
          r   <= '0;
          cnt <= '0;
          sat <= 1'b0;
        end
        ITER: if (!abort) begin
          r   <= temp;
          q   <= {q[N-2:0], q_bit};
          a   <= {a[W_IN-3:0], 2'b00};
          cnt <= cnt + 1'b1;
        end
        CORR: if (!abort) begin
          rem  <= rem_c;
          root <= root_c;
          sat  <= sat_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_radicador_param.sv
// Directed bench: two 32-bit units (truncate and round) share stimulus,
// an 8-bit unit is swept exhaustively; an integer-sqrt model supplies expectations.
module tb_radicador_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start32 = 1'b0, abort32 = 1'b0;
  logic [31:0] x32 = '0;
  logic        busy_t, fin_t, sat_t, busy_r, fin_r, sat_r;
  logic [15:0] root_t, root_r;
  logic [16:0] rem_t, rem_r;

  logic        start8 = 1'b0, abort8 = 1'b0;
  logic [7:0]  x8 = '0;
  logic        busy8, fin8, sat8;
  logic [3:0]  root8;
  logic [4:0]  rem8;

  int nvec = 0;
  int nerr = 0;

  longint exp_root_t, exp_root_r, exp_rem32, exp_sat_r;
  longint exp_root8, exp_rem8;
  bit     exp_v32 = 0, exp_v8 = 0;

  always #5 clk = ~clk;

  radicador_param #(.W_IN(32), .ROUND(1'b0)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(start32), .abort(abort32), .x(x32),
    .busy(busy_t), .fin(fin_t), .root(root_t), .rem(rem_t), .sat(sat_t));

  radicador_param #(.W_IN(32), .ROUND(1'b1)) dut_r (
    .clk(clk), .rst_n(rst_n), .start(start32), .abort(abort32), .x(x32),
    .busy(busy_r), .fin(fin_r), .root(root_r), .rem(rem_r), .sat(sat_r));

  radicador_param #(.W_IN(8), .ROUND(1'b0)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8), .x(x8),
    .busy(busy8), .fin(fin8), .root(root8), .rem(rem8), .sat(sat8));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Floor sqrt by bitwise search, then the rounding rule on top of it.
  task automatic model(input longint v, input int n,
                       output longint s, output longint rm,
                       output longint rnd, output longint st);
    longint t;
    s = 0;
    for (int b = n - 1; b >= 0; b--) begin
      t = s + (longint'(1) << b);
      if (t * t <= v) s = t;
    end
    rm  = v - s * s;
    rnd = s;
    st  = 0;
    if (rm > s) begin
      if (s == (longint'(1) << n) - 1) st = 1;
      else rnd = s + 1;
    end
  endtask

  task automatic run32(input logic [31:0] v);
    longint s, rm, rnd, st;
    int lat;
    model(longint'(v), 16, s, rm, rnd, st);
    exp_root_t = s; exp_rem32 = rm; exp_root_r = rnd; exp_sat_r = st;
    exp_v32 = 1;
    x32 = v; start32 = 1'b1;
    @(posedge clk); #1;
    chk("busy32_after_capture", busy_t, 1);
    x32 = $urandom;
    lat = 0;
    while (!fin_t && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("lat32", lat, 17);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_done32", {fin_t, fin_r}, 2'b11);
    start32 = 1'b0;
    @(posedge clk); #1;
    chk("release32", fin_t, 0);
  endtask

  task automatic run8(input logic [7:0] v, input bit chk_lat);
    longint s, rm, rnd, st;
    int lat;
    model(longint'(v), 4, s, rm, rnd, st);
    exp_root8 = s; exp_rem8 = rm; exp_v8 = 1;
    x8 = v; start8 = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!fin8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (chk_lat || lat != 5) chk("lat8", lat, 5);
    start8 = 1'b0;
    @(posedge clk); #1;
  endtask

  // Continuous compare of results whenever a unit reports completion.
  always @(negedge clk) begin
    if (rst_n && exp_v32 && fin_t) begin
      chk("root_trunc", root_t, exp_root_t);
      chk("rem_trunc", rem_t, exp_rem32);
      chk("sat_trunc", sat_t, 0);
      chk("root_round", root_r, exp_root_r);
      chk("rem_round", rem_r, exp_rem32);
      chk("sat_round", sat_r, exp_sat_r);
    end
    if (rst_n && exp_v8 && fin8) begin
      chk("root8", root8, exp_root8);
      chk("rem8", rem8, exp_rem8);
      chk("sat8", sat8, 0);
    end
  end

  initial begin
    longint s, rm, rnd, st;
    longint prev_root;
    bit     seen;

    // Model pins
    model(200, 4, s, rm, rnd, st);
    chk("model_200", {s[15:0], rm[15:0]}, {16'd14, 16'd4});
    model(3, 16, s, rm, rnd, st);
    chk("model_3_round", rnd, 2);
    model(64'hFFFF_FFFF, 16, s, rm, rnd, st);
    chk("model_max_sat", {rm[31:0], st[7:0]}, {32'h1FFFE, 8'd1});

    // Reset state
    #2;
    chk("reset_outs32", {busy_t, fin_t, sat_t, root_t, rem_t}, '0);
    chk("reset_outs8", {busy8, fin8, sat8, root8, rem8}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run32(32'h0);
    chk("lit_zero", {root_t, rem_t, sat_t}, '0);
    run32(32'hFFFF_FFFF);
    chk("lit_max_trunc", {root_t, rem_t}, {16'hFFFF, 17'h1FFFE});
    chk("lit_max_round", {root_r, sat_r}, {16'hFFFF, 1'b1});
    run32(32'd3);
    chk("lit_3_round", {root_r, rem_r, sat_r}, {16'd2, 17'd2, 1'b0});
    run32(32'd2);
    chk("lit_2_round", {root_r, rem_r}, {16'd1, 17'd1});
    run32(32'h0001_0000);
    chk("lit_10000_round", {root_r, rem_r}, {16'h100, 17'd0});
    run32(32'hFFFE_0001);
    for (int i = 0; i < 6; i++) run32($urandom);

    // 8-bit sweep
    run8(8'd200, 1'b1);
    chk("lit_200", {root8, rem8}, {4'd14, 5'd4});
    for (int v = 0; v < 256; v++) run8(v[7:0], 1'b0);

    // Abort during the third iteration cycle
    run32(32'h1234_5678);
    prev_root = exp_root_t;
    x32 = 32'd99; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort32 = 1'b1;
    @(posedge clk); #1;
    abort32 = 1'b0;
    chk("abort_idle", {busy_t, fin_t, busy_r, fin_r}, 4'b0000);
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (fin_t || fin_r) seen = 1;
    end
    chk("abort_no_fin", seen, 0);
    chk("abort_keeps_root", root_t, prev_root[15:0]);
    run32(32'd100);
    chk("after_abort", root_t, 16'd10);

    // Asynchronous reset in the middle of ITER
    x32 = 32'hFFFF_FFFF; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {busy_t, fin_t, root_t, rem_t, sat_t, busy_r, root_r, sat_r}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_stays_idle", {busy_t, fin_t}, 2'b00);
    run32(32'd1_000_000);

    exp_v32 = 0; exp_v8 = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
